prio_encoder_seq: RTL and testbench
===================================

PRIO_ENCODER_SEQ -- requirements
Module: prio_encoder_seq

Interface
REQ-001 SHALL have parameter N, default 8: request vector width, N >= 2.
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 emits the lowest set index first, 1 emits the highest set index first.
REQ-003 SHALL derive localparam W = clog2(N): index width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  producer offers in_vec.
REQ-007 in_ready  output  1  block accepts in_vec this cycle.
REQ-008 in_vec  input  N  request vector, any number of bits set.
REQ-009 out_valid  output  1  out_idx is valid.
REQ-010 out_ready  input  1  consumer takes out_idx.
REQ-011 out_idx  output  W  index of the currently selected set bit.
REQ-012 out_last  output  1  out_idx is the final set bit of the captured vector.

Function
REQ-013 SHALL hold a pending register of N bits and a state of IDLE or SCAN.
REQ-014 Accept occurs when in_valid and in_ready are both high in the same cycle.
REQ-015 in_ready SHALL be 1 in IDLE; in SCAN it SHALL be 1 only when out_valid, out_ready and out_last are all high (combinational from out_ready).
REQ-016 On accept of a nonzero in_vec, pending <= in_vec and the state SHALL become SCAN.
REQ-017 On accept of in_vec == 0, the vector SHALL be dropped: no output, and the state becomes or stays IDLE.
REQ-018 out_valid SHALL be 1 exactly when the state is SCAN; the first index is presented one cycle after accept.
REQ-019 out_idx SHALL be the lowest set index of pending if MSB_FIRST = 0, else the highest; it SHALL be 0 when pending == 0.
REQ-020 out_last SHALL be 1 iff out_valid and pending has exactly one bit set.
REQ-021 On out_valid and out_ready, the bit at out_idx SHALL be cleared in pending: one index per cycle, each set bit emitted exactly once.
REQ-022 When out_valid is high and out_ready is low, out_idx, out_last and pending SHALL hold.
REQ-023 On the last pop (out_last and out_ready):
- with no simultaneous accept: the state SHALL become IDLE.
- with a simultaneous accept of a nonzero vector: pending SHALL load the new vector and the state SHALL stay SCAN, with no bubble.
- with a simultaneous accept of a zero vector: the state SHALL become IDLE.
REQ-024 in_vec SHALL be ignored whenever in_ready is 0.
REQ-025 N = 4 with a one-hot in_vec SHALL yield the same index as a combinational 4-to-2 encoder, with out_last = 1.

Reset
REQ-026 While rst is high at a clock edge: pending <= 0 and state <= IDLE; any in-progress vector is discarded.
REQ-027 After reset: out_valid = 0, out_idx = 0, out_last = 0, in_ready = 1.
REQ-028 Reset SHALL take priority over accept and pop in the same cycle.

Structure
REQ-029 Shared package enc_pkg SHALL hold the state typedef (IDLE, SCAN) and the default-N constant.
REQ-030 The combinational index finder SHALL be sub-module prio_index (parameters N, MSB_FIRST; input vec; outputs idx and onehot_last); prio_encoder_seq instantiates it once.
REQ-031 No combinational path other than out_ready -> in_ready is permitted.

Verification
REQ-032 The bench SHALL cover the following directed scenarios, with N = 8 unless stated:
- LSB-first, in_vec = 8'b1010_0100, out_ready = 1 -> out_idx 2, 5, 7 on three consecutive cycles; out_last only with 7; then out_valid = 0.
- MSB_FIRST = 1, same vector -> out_idx 7, 5, 2; out_last with 2.
- out_ready held low 3 cycles after out_valid rises with vector 8'h90 -> out_idx = 4 stable, out_valid stays high; then 4, 7 emitted.
- in_vec = 8'h00 accepted -> out_valid stays 0 and in_ready stays 1.
- vector 8'h80, then 8'h01 offered during its last pop -> 8'h01 accepted in the same cycle; next cycle out_idx = 0 with out_last = 1, no idle cycle.
- rst pulsed after the first pop of 8'hFF -> next cycle out_valid = 0, out_idx = 0, in_ready = 1; a new vector 8'h08 then yields out_idx 3 with out_last = 1.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and constants for the sequential priority encoder.
package enc_pkg;

  // Request vector width used when the instantiating code does not override it.
  localparam int unsigned DEFAULT_N = 8;

  // Control state: IDLE waits for a vector, SCAN emits its set bits one per pop.
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/prio_index.sv
// Combinational index finder: picks the lowest (or highest) set bit of vec and
// flags whether vec holds exactly one set bit.
module prio_index #(
  parameter int unsigned N         = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 onehot_last
);

  localparam int unsigned W = $clog2(N);

  // Scan toward the preferred end so the last match wins; idx stays 0 for vec == 0.
  always_comb begin
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < int'(N); i++) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign onehot_last = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/prio_encoder_seq.sv
// Sequential priority encoder: captures a request vector and emits the index of
// each set bit once, one per accepted output beat, with back-to-back reload.
module prio_encoder_seq
  import enc_pkg::*;
#(
  parameter int unsigned N         = DEFAULT_N,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last
);

  localparam int unsigned W = $clog2(N);

  state_e         r_state;
  state_e         w_state_d;
  logic [N-1:0]   r_pending;
  logic [N-1:0]   w_pending_d;
  logic [N-1:0]   w_clear_mask;
  logic [W-1:0]   w_idx;
  logic           w_onehot;
  logic           w_pop;
  logic           w_last_pop;
  logic           w_accept;

  prio_index #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio_index (
    .vec         (r_pending),
    .idx         (w_idx),
    .onehot_last (w_onehot)
  );

  assign out_valid  = (r_state == SCAN);
  assign out_idx    = w_idx;
  assign out_last   = out_valid & w_onehot;
  assign w_pop      = out_valid & out_ready;
  assign w_last_pop = w_pop & out_last;
  // Reload during the final pop avoids an idle bubble between vectors.
  assign in_ready   = (r_state == IDLE) | w_last_pop;
  assign w_accept   = in_valid & in_ready;

  // Next state: an accept overrides the pop it may coincide with; a zero vector is dropped.
  always_comb begin
    w_state_d    = r_state;
    w_pending_d  = r_pending;
    w_clear_mask = '0;
    w_clear_mask[w_idx] = 1'b1;
    if (w_accept) begin
      w_pending_d = in_vec;
      w_state_d   = (in_vec != '0) ? SCAN : IDLE;
    end else if (w_pop) begin
      w_pending_d = r_pending & ~w_clear_mask;
      if (out_last) w_state_d = IDLE;
    end
  end

  // State and pending registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_d;
      r_pending <= w_pending_d;
    end
  end

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Scoreboard bench for prio_encoder_seq: LSB-first and MSB-first N=8 instances
// share stimulus; an N=4 instance checks one-hot encoding.
module tb_prio_encoder_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_vec = '0;
  logic       out_ready = 1'b1;

  logic       l_in_ready, l_out_valid, l_out_last;
  logic [2:0] l_out_idx;
  logic       m_in_ready, m_out_valid, m_out_last;
  logic [2:0] m_out_idx;

  logic       in_valid4 = 1'b0;
  logic [3:0] in_vec4 = '0;
  logic       out_ready4 = 1'b1;
  logic       f_in_ready, f_out_valid, f_out_last;
  logic [1:0] f_out_idx;

  int n_cmp = 0;
  int n_err = 0;
  int q_lsb[$];
  int q_msb[$];
  int q_n4[$];

  always #5 clk = ~clk;

  prio_encoder_seq #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready), .in_vec(in_vec),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_idx(l_out_idx), .out_last(l_out_last)
  );

  prio_encoder_seq #(.N(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_vec(in_vec),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_idx(m_out_idx), .out_last(m_out_last)
  );

  prio_encoder_seq #(.N(4), .MSB_FIRST(1'b0)) dut_n4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(f_in_ready), .in_vec(in_vec4),
    .out_valid(f_out_valid), .out_ready(out_ready4), .out_idx(f_out_idx), .out_last(f_out_last)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected beats are encoded as idx*2 + last.
  function automatic void push_exp(input logic [7:0] v);
    int cnt = 0;
    int k;
    for (int i = 0; i < 8; i++) if (v[i]) cnt++;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        k++;
        q_lsb.push_back(i * 2 + ((k == cnt) ? 1 : 0));
      end
    end
    k = 0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        k++;
        q_msb.push_back(i * 2 + ((k == cnt) ? 1 : 0));
      end
    end
  endfunction

  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic offer(input logic [7:0] v, output int waits);
    in_valid = 1'b1;
    in_vec   = v;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (l_in_ready) break;
      waits++;
      if (waits > 50) begin
        chk("offer_timeout", waits, 0);
        break;
      end
    end
    if (l_in_ready) push_exp(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_vec   = 8'($urandom);
  endtask

  // Output monitor: every popped beat is compared with the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (l_out_valid && out_ready) begin
        if (q_lsb.size() == 0) chk("lsb_extra", 1, 0);
        else chk("lsb_out", int'(l_out_idx) * 2 + int'(l_out_last), q_lsb.pop_front());
      end
      if (m_out_valid && out_ready) begin
        if (q_msb.size() == 0) chk("msb_extra", 1, 0);
        else chk("msb_out", int'(m_out_idx) * 2 + int'(m_out_last), q_msb.pop_front());
      end
      if (f_out_valid && out_ready4) begin
        if (q_n4.size() == 0) chk("n4_extra", 1, 0);
        else chk("n4_out", int'(f_out_idx) * 2 + int'(f_out_last), q_n4.pop_front());
      end
    end
  end

  initial begin
    int w;
    logic acc;
    logic [7:0] v;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_l_valid", l_out_valid, 0);
    chk("rst_l_idx", l_out_idx, 0);
    chk("rst_l_last", l_out_last, 0);
    chk("rst_l_ready", l_in_ready, 1);
    chk("rst_m_valid", m_out_valid, 0);
    chk("rst_f_ready", f_in_ready, 1);
    @(posedge clk);
    #1;

    // 1010_0100 streamed with out_ready high: three consecutive beats then idle.
    offer(8'b1010_0100, w);
    repeat (3) begin
      @(negedge clk);
      chk("a4_valid", l_out_valid, 1);
    end
    @(negedge clk);
    chk("a4_done", l_out_valid, 0);
    @(posedge clk);
    #1;

    // Stall with out_ready low: outputs hold.
    out_ready = 1'b0;
    offer(8'h90, w);
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", l_out_valid, 1);
      chk("stall_idx", l_out_idx, 4);
      chk("stall_last", l_out_last, 0);
      chk("stall_m_idx", m_out_idx, 7);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Zero vector is accepted and dropped.
    offer(8'h00, w);
    repeat (3) begin
      @(negedge clk);
      chk("zero_valid", l_out_valid, 0);
      chk("zero_ready", l_in_ready, 1);
    end
    @(posedge clk);
    #1;

    // Reload during the last pop: no bubble.
    offer(8'h80, w);
    offer(8'h01, w);
    chk("chain_wait", w, 0);
    @(negedge clk);
    chk("chain_valid", l_out_valid, 1);
    chk("chain_idx", l_out_idx, 0);
    chk("chain_last", l_out_last, 1);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-vector discards the remainder.
    offer(8'hFF, w);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q_lsb.delete();
    q_msb.delete();
    @(negedge clk);
    chk("mrst_valid", l_out_valid, 0);
    chk("mrst_idx", l_out_idx, 0);
    chk("mrst_ready", l_in_ready, 1);
    chk("mrst_m_valid", m_out_valid, 0);
    @(posedge clk);
    #1;
    offer(8'h08, w);
    @(negedge clk);
    chk("post_idx", l_out_idx, 3);
    chk("post_last", l_out_last, 1);
    repeat (2) @(posedge clk);
    #1;

    // N=4 one-hot matches a 4-to-2 encoder.
    for (int i = 0; i < 4; i++) begin
      in_valid4 = 1'b1;
      in_vec4   = 4'b0001 << i;
      @(negedge clk);
      chk("n4_ready", f_in_ready, 1);
      q_n4.push_back(i * 2 + 1);
      @(posedge clk);
      #1 in_valid4 = 1'b0;
      @(posedge clk);
      #1;
    end

    // Random traffic with random backpressure.
    acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        in_vec   = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && ($urandom_range(0, 2) == 0)) begin
        v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        in_valid = 1'b1;
        in_vec   = v;
      end
      @(negedge clk);
      acc = in_valid && l_in_ready;
      if (acc) push_exp(in_vec);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (q_lsb.size() == 0 && q_msb.size() == 0 && !l_out_valid) break;
    end
    chk("drain_lsb", q_lsb.size(), 0);
    chk("drain_msb", q_msb.size(), 0);
    chk("drain_n4", q_n4.size(), 0);
    chk("drain_idle", l_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
